// File: rtl/csr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// csr_cmd_sequencer
//   Byte-stream CSR command engine. The command byte is {we, rep[1:0], tgt,
//   addr_high[3:0]}. It is followed by ADDR_LO_BYTES address bytes (MSB
//   first). The engine then runs nrep bus transfers to the CSR space (tgt=0)
//   or to the NKMD PROM (tgt=1). Read data is returned on the output byte
//   stream.
//   rep=00 with addr_high!=F is a NOP. rep=00 with addr_high==F is a special
//   command, and the byte after it is its argument.
//
// Parameters
//   ADDR_LO_BYTES  number of low address bytes; ADDR_W = 4 + 8*ADDR_LO_BYTES
//   REP_SHIFT      nrep = 1 << (REP_SHIFT*(rep-1)) for rep = 1..3
//
// Configuration macro
//   CSR_SEQ_AUTOINC_EN  when defined, bus_addr increments after every acked
//                       transfer and wraps modulo 2^ADDR_W. When undefined,
//                       the address stays fixed for the whole burst.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready/in_data       command, address and write-data bytes in
//   bus_req/bus_we/bus_tgt          transfer request and its attributes
//   bus_addr/bus_wdata              transfer address and write data
//   bus_ack/bus_rdata               completion strobe and read data
//   out_valid/out_ready/out_data    read-data bytes out
//   special_valid/special_arg       special-command pulse and its argument
//   busy                            engine not idle
// ---------------------------------------------------------------------------
module csr_cmd_sequencer #(
    parameter  int unsigned ADDR_LO_BYTES = 1,
    parameter  int unsigned REP_SHIFT     = 2,
    localparam int unsigned ADDR_W        = 4 + 8 * ADDR_LO_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic              bus_tgt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic              bus_ack,
    input  logic [7:0]        bus_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              special_valid,
    output logic [7:0]        special_arg,
    output logic              busy
);

    localparam int unsigned LO_W  = 8 * ADDR_LO_BYTES;
    localparam int unsigned CNT_W = 2 * REP_SHIFT + 1;
    localparam int unsigned BC_W  = (ADDR_LO_BYTES > 1) ? $clog2(ADDR_LO_BYTES) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_SPEC_ARG = 3'd2;
    localparam logic [2:0] S_WDATA    = 3'd3;
    localparam logic [2:0] S_WREQ     = 3'd4;
    localparam logic [2:0] S_RREQ     = 3'd5;
    localparam logic [2:0] S_ROUT     = 3'd6;

    logic [2:0]        state_q,       state_d;
    logic              in_ready_q,    in_ready_d;
    logic              we_q,          we_d;
    logic              tgt_q,         tgt_d;
    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [7:0]        wdata_q,       wdata_d;
    logic [7:0]        rdata_q,       rdata_d;
    logic [CNT_W-1:0]  remaining_q,   remaining_d;
    logic [BC_W-1:0]   byte_cnt_q,    byte_cnt_d;
    logic [7:0]        special_arg_q, special_arg_d;
    logic              special_valid_q, special_valid_d;

    logic              accept;
    logic [CNT_W-1:0]  nrep;
    logic [LO_W+7:0]   lo_shift;
    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        accept = in_valid & in_ready_q;

        unique case (in_data[6:5])
            2'd1:    nrep = CNT_W'(1);
            2'd2:    nrep = CNT_W'(1) << REP_SHIFT;
            2'd3:    nrep = CNT_W'(1) << (2 * REP_SHIFT);
            default: nrep = '0;
        endcase

        // Low address bytes arrive MSB first, so each byte shifts in at the bottom.
        lo_shift = {addr_q[LO_W-1:0], in_data};

`ifdef CSR_SEQ_AUTOINC_EN
        addr_next = addr_q + ADDR_W'(1);
`else
        addr_next = addr_q;
`endif

        state_d         = state_q;
        we_d            = we_q;
        tgt_d           = tgt_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        remaining_d     = remaining_q;
        byte_cnt_d      = byte_cnt_q;
        special_arg_d   = special_arg_q;
        special_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_data[6:5] == 2'b00) begin
                        if (in_data[3:0] == 4'hF) begin
                            state_d = S_SPEC_ARG;
                        end
                    end else begin
                        we_d                      = in_data[7];
                        tgt_d                     = in_data[4];
                        addr_d                    = '0;
                        addr_d[ADDR_W-1 -: 4]     = in_data[3:0];
                        remaining_d               = nrep;
                        byte_cnt_d                = '0;
                        state_d                   = S_ADDR;
                    end
                end
            end
            S_SPEC_ARG: begin
                if (accept) begin
                    special_arg_d   = in_data;
                    special_valid_d = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d[LO_W-1:0] = lo_shift[LO_W-1:0];
                    if (byte_cnt_q == BC_W'(ADDR_LO_BYTES - 1)) begin
                        state_d = we_q ? S_WDATA : S_RREQ;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            S_WDATA: begin
                if (accept) begin
                    wdata_d = in_data;
                    state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                if (bus_ack) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    addr_d      = addr_next;
                    state_d     = (remaining_q > CNT_W'(1)) ? S_WDATA : S_IDLE;
                end
            end
            S_RREQ: begin
                if (bus_ack) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    addr_d      = addr_next;
                    rdata_d     = bus_rdata;
                    state_d     = S_ROUT;
                end
            end
            S_ROUT: begin
                // remaining was already decremented on the ack, so any
                // nonzero value means more reads are outstanding.
                if (out_ready) begin
                    state_d = (remaining_q != '0) ? S_RREQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // in_ready is registered from the next state, so it stays low in reset
        // and has no combinational path from in_valid.
        in_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                     (state_d == S_SPEC_ARG) || (state_d == S_WDATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            in_ready_q      <= 1'b0;
            we_q            <= 1'b0;
            tgt_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            remaining_q     <= '0;
            byte_cnt_q      <= '0;
            special_arg_q   <= '0;
            special_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            we_q            <= we_d;
            tgt_q           <= tgt_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rdata_q         <= rdata_d;
            remaining_q     <= remaining_d;
            byte_cnt_q      <= byte_cnt_d;
            special_arg_q   <= special_arg_d;
            special_valid_q <= special_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign bus_req       = (state_q == S_WREQ) || (state_q == S_RREQ);
    assign bus_we        = we_q;
    assign bus_tgt       = tgt_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign out_valid     = (state_q == S_ROUT);
    assign out_data      = rdata_q;
    assign special_valid = special_valid_q;
    assign special_arg   = special_arg_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csr_cmd_sequencer
//   Randomized self-checking bench for csr_cmd_sequencer with its default
//   parameters (1 low address byte, 1/4/16 repeats). Expected bus transfers,
//   read bytes and special arguments come from a queue-based model built from
//   the command byte fields.
// ---------------------------------------------------------------------------
module tb_csr_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        bus_req, bus_we, bus_tgt;
    logic [11:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        special_valid;
    logic [7:0]  special_arg;
    logic        busy;

    csr_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_tgt(bus_tgt),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .special_valid(special_valid), .special_arg(special_arg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    typedef struct packed {
        logic        we;
        logic        tgt;
        logic [11:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] spec_q[$];

    bit         auto_resp = 1'b0;
    bit         hold_out  = 1'b0;
    bit         rd_fix_en = 1'b0;
    logic [7:0] rd_fix    = 8'h00;
    int         man_req   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus responder: random ack latency, checks each acked request against the model.
    initial begin : responder
        int   man_done;
        txn_t t;
        man_done  = 0;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk); #1;
            bus_ack = 1'b0;
            if (man_req != man_done) begin
                man_done++;
                bus_ack = 1'b1;
            end else if (auto_resp && bus_req && !rst && $urandom_range(0, 2) == 0) begin
                check("bus_expected", 32'(exp_q.size() != 0), 32'd1);
                bus_ack = 1'b1;
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("bus_we",   32'(bus_we),   32'(t.we));
                    check("bus_tgt",  32'(bus_tgt),  32'(t.tgt));
                    check("bus_addr", 32'(bus_addr), 32'(t.addr));
                    if (t.we) check("bus_wdata", 32'(bus_wdata), 32'(t.wdata));
                    if (!t.we) begin
                        bus_rdata = rd_fix_en ? rd_fix : 8'($urandom);
                        rd_q.push_back(bus_rdata);
                    end
                end
            end
        end
    end

    // Output consumer with random back-pressure.
    initial begin : consumer
        out_ready = 1'b0;
        forever begin
            @(negedge clk); #1;
            out_ready = hold_out ? 1'b0 : ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) check("out_data", 32'(out_data), 32'(rd_q.pop_front()));
            end
        end
    end

    initial begin : special_mon
        forever begin
            @(negedge clk); #1;
            if (special_valid) begin
                check("spec_expected", 32'(spec_q.size() != 0), 32'd1);
                if (spec_q.size() != 0) check("special_arg", 32'(special_arg), 32'(spec_q.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reference model: expected effects of one command, from its byte fields.
    task automatic model_cmd(input logic [7:0] cmd, input logic [7:0] lo, input logic [7:0] d [16]);
        int unsigned nrep;
        logic [11:0] base;
        txn_t        t;
        if (cmd[6:5] == 2'b00) begin
            if (cmd[3:0] == 4'hF) spec_q.push_back(lo);
            return;
        end
        nrep = 1 << (2 * (int'(cmd[6:5]) - 1));
        base = {cmd[3:0], lo};
        for (int unsigned i = 0; i < nrep; i++) begin
            t.we  = cmd[7];
            t.tgt = cmd[4];
`ifdef CSR_SEQ_AUTOINC_EN
            t.addr = 12'(base + i);
`else
            t.addr = base;
`endif
            t.wdata = cmd[7] ? d[i] : 8'h00;
            exp_q.push_back(t);
        end
    endtask

    task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] lo, input bit seq);
        logic [7:0]  d [16];
        int unsigned nrep;
        for (int i = 0; i < 16; i++) d[i] = seq ? 8'(8'h11 + i) : 8'($urandom);
        model_cmd(cmd, lo, d);
        send_byte(cmd);
        if (cmd[6:5] == 2'b00) begin
            if (cmd[3:0] == 4'hF) send_byte(lo);
            return;
        end
        nrep = 1 << (2 * (int'(cmd[6:5]) - 1));
        send_byte(lo);
        if (cmd[7]) for (int unsigned i = 0; i < nrep; i++) send_byte(d[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || rd_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"},     32'(busy),         32'd0);
        check({tag, "_bus_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rd_left"},  32'(rd_q.size()),  32'd0);
    endtask

    initial begin : main
        logic [7:0]  d [16];
        int unsigned c0;
        int          n;

        // Reset values.
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready",      32'(in_ready),      32'd0);
        check("rst_bus_req",       32'(bus_req),       32'd0);
        check("rst_out_valid",     32'(out_valid),     32'd0);
        check("rst_special_valid", 32'(special_valid), 32'd0);
        check("rst_busy",          32'(busy),          32'd0);
        check("rst_bus_addr",      32'(bus_addr),      32'd0);
        check("rst_out_data",      32'(out_data),      32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        auto_resp = 1'b1;

        // Stray ack in IDLE, then a 4-write burst with a stray ack in WDATA.
        man_req++;
        @(negedge clk); @(negedge clk);
        check("idle_ack_busy",     32'(busy),     32'd0);
        check("idle_ack_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) d[i] = 8'(8'h11 + i);
        model_cmd(8'hC3, 8'h10, d);
        send_byte(8'hC3);
        send_byte(8'h10);
        man_req++;
        @(negedge clk); @(negedge clk);
        check("wdata_ack_busy",     32'(busy),     32'd1);
        check("wdata_ack_in_ready", 32'(in_ready), 32'd1);
        check("wdata_ack_bus_req",  32'(bus_req),  32'd0);
        for (int i = 0; i < 4; i++) send_byte(d[i]);
        wait_idle("burst4");

        // Reset while a write request is pending.
        auto_resp = 1'b0;
        send_byte(8'hA3);
        send_byte(8'h10);
        send_byte(8'h55);
        check("wreq_bus_req", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_bus_req",   32'(bus_req),   32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        auto_resp = 1'b1;

        // Single PROM read held under back-pressure.
        rd_fix_en = 1'b1;
        rd_fix    = 8'h5A;
        hold_out  = 1'b1;
        do_cmd(8'h35, 8'h02, 1'b0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rd_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_hold_valid",    32'(out_valid), 32'd1);
            check("rd_hold_data",     32'(out_data),  32'h5A);
            check("rd_hold_in_ready", 32'(in_ready),  32'd0);
        end
        hold_out  = 1'b0;
        rd_fix_en = 1'b0;
        wait_idle("read1");

        // Special command, then back-to-back NOPs.
        do_cmd(8'h0F, 8'h77, 1'b0);
        check("spec_pulse", 32'(special_valid), 32'd1);
        check("spec_arg",   32'(special_arg),   32'h77);
        @(negedge clk);
        check("spec_pulse_end", 32'(special_valid), 32'd0);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00);
            check("nop_busy",     32'(busy),          32'd0);
            check("nop_in_ready", 32'(in_ready),      32'd1);
            check("nop_bus_req",  32'(bus_req),       32'd0);
            check("nop_special",  32'(special_valid), 32'd0);
        end
        check("nop_rate",     32'(cyc - c0),      32'd3);
        check("spec_arg_hold", 32'(special_arg), 32'h77);

        // 16-write PROM burst crossing the top of the address space.
        do_cmd(8'hFF, 8'hFF, 1'b0);
        wait_idle("burst16");

        // Random commands.
        for (int k = 0; k < 40; k++) begin
            do_cmd(8'($urandom), 8'($urandom), 1'b0);
            wait_idle("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
